mem_arbiter: RTL and testbench

- Shares the MCU's single-port 32x8 memory between two requesters: the CPU controller and a host loader/debug port.
- Sits between the CPU datapath (rd/wr/address mux/accumulator out) and the memory array.
- CPU has default ownership. The host is granted single-cycle slots, with a starvation bound.
- The CPU is frozen through cpu_stall; the upstream state register holds pstate while stall=1.

---
 rtl/mcu_pkg.sv | 43 ++++
 rtl/arb_wait_ctr.sv | 38 +++
 rtl/mem_arbiter.sv | 119 +++++++++++
 tb/tb_mem_arbiter.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/mcu_pkg.sv
// Shared MCU definitions: bus widths, arbiter state encoding,
// CPU opcodes and control-state encodings.
package mcu_pkg;

    localparam int AW_DEF       = 5;
    localparam int DW_DEF       = 8;
    localparam int MAX_WAIT_DEF = 3;
    localparam int WAIT_CW      = 4;

    typedef enum logic {
        CPU_OWN  = 1'b0,
        HOST_OWN = 1'b1
    } arb_state_e;

    typedef enum logic [2:0] {
        OP_HALT = 3'd0,
        OP_SKZ  = 3'd1,
        OP_ADD  = 3'd2,
        OP_AND  = 3'd3,
        OP_XOR  = 3'd4,
        OP_LDA  = 3'd5,
        OP_STO  = 3'd6,
        OP_JUMP = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        PS_INST_ADDR  = 3'd0,
        PS_INST_FETCH = 3'd1,
        PS_INST_LOAD  = 3'd2,
        PS_IDLE       = 3'd3,
        PS_OP_ADDR    = 3'd4,
        PS_OP_FETCH   = 3'd5,
        PS_ALU_OP     = 3'd6,
        PS_STORE      = 3'd7
    } pstate_e;

    // Opcodes whose operand phase touches memory.
    function automatic logic op_uses_mem(input opcode_e op);
        return (op == OP_ADD) || (op == OP_AND) || (op == OP_XOR) ||
               (op == OP_LDA) || (op == OP_STO);
    endfunction

endpackage

// File: rtl/arb_wait_ctr.sv
// Saturating count of CPU memory cycles taken while the host waits.
import mcu_pkg::*;

module arb_wait_ctr #(
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic clr_i,
    output logic sat_o
);

    localparam logic [WAIT_CW-1:0] MAX_W = WAIT_CW'(MAX_WAIT);

    logic [WAIT_CW-1:0] cnt_q;
    logic [WAIT_CW-1:0] cnt_d;

    assign sat_o = (cnt_q == MAX_W);

    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && !sat_o) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU owns the array by default, the host
// gets one-cycle slots when the CPU is idle, halted or has starved it.
import mcu_pkg::*;

module mem_arbiter #(
    parameter int AW       = AW_DEF,
    parameter int DW       = DW_DEF,
    parameter int MAX_WAIT = MAX_WAIT_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cpu_rd,
    input  logic          cpu_wr,
    input  logic [AW-1:0] cpu_addr,
    input  logic [DW-1:0] cpu_wdata,
    input  logic          cpu_halted,
    output logic [DW-1:0] cpu_rdata,
    output logic          cpu_stall,
    input  logic          host_req,
    input  logic          host_we,
    input  logic [AW-1:0] host_addr,
    input  logic [DW-1:0] host_wdata,
    output logic          host_ack,
    output logic [DW-1:0] host_rdata,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_rd,
    output logic          mem_wr,
    input  logic [DW-1:0] mem_rdata,
    output logic          arb_err
);

    arb_state_e    state_q, state_d;
    logic          ack_q, ack_d;
    logic [DW-1:0] rdata_q, rdata_d;
    logic          err_q, err_d;

    logic cpu_acc;
    logic host_elig;
    logic ctr_inc;
    logic ctr_clr;
    logic ctr_sat;

    assign cpu_acc   = cpu_rd | cpu_wr;
    // The ack cycle masks host_req so the CPU always gets a cycle in between.
    assign host_elig = host_req & ~ack_q;

    arb_wait_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_wait_ctr (
        .clk   (clk),
        .rst_n (rst_n),
        .inc_i (ctr_inc),
        .clr_i (ctr_clr),
        .sat_o (ctr_sat)
    );

    always_comb begin
        state_d   = state_q;
        ack_d     = 1'b0;
        rdata_d   = rdata_q;
        ctr_inc   = 1'b0;
        ctr_clr   = 1'b0;
        cpu_stall = 1'b0;
        mem_addr  = cpu_addr;
        mem_wdata = cpu_wdata;
        mem_wr    = cpu_wr;
        mem_rd    = cpu_rd & ~cpu_wr;
        unique case (state_q)
            CPU_OWN: begin
                if (host_elig) begin
                    if (!cpu_acc || cpu_halted || ctr_sat) begin
                        state_d = HOST_OWN;
                    end else begin
                        ctr_inc = 1'b1;
                    end
                end
            end
            HOST_OWN: begin
                mem_addr  = host_addr;
                mem_wdata = host_wdata;
                mem_wr    = host_we;
                mem_rd    = ~host_we;
                cpu_stall = cpu_acc;
                ctr_clr   = 1'b1;
                ack_d     = 1'b1;
                state_d   = CPU_OWN;
                if (!host_we) begin
                    rdata_d = mem_rdata;
                end
            end
            default: begin
                state_d = CPU_OWN;
            end
        endcase
    end

    assign err_d = err_q | (cpu_rd & cpu_wr);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= CPU_OWN;
            ack_q   <= 1'b0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign cpu_rdata  = mem_rdata;
    assign host_ack   = ack_q;
    assign host_rdata = rdata_q;
    assign arb_err    = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter with a 32x8 memory model.
module tb_mem_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cpu_rd, cpu_wr, cpu_halted;
    logic [4:0] cpu_addr;
    logic [7:0] cpu_wdata, cpu_rdata;
    logic       cpu_stall;
    logic       host_req, host_we, host_ack;
    logic [4:0] host_addr;
    logic [7:0] host_wdata, host_rdata;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata, mem_rdata;
    logic       mem_rd, mem_wr, arb_err;

    logic [7:0] mem [32];

    typedef struct packed {
        logic [4:0] a;
        logic       rd;
        logic       wr;
        logic       st;
        logic       ack;
        logic       err;
        logic [7:0] hrd;
    } exp_t;

    exp_t       exp_q [$];
    logic [7:0] ack_q [$];
    int         n_cmp = 0;
    int         n_bad = 0;
    int         cyc_k = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW       (5),
        .DW       (8),
        .MAX_WAIT (3)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .cpu_addr   (cpu_addr),
        .cpu_wdata  (cpu_wdata),
        .cpu_halted (cpu_halted),
        .cpu_rdata  (cpu_rdata),
        .cpu_stall  (cpu_stall),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_ack   (host_ack),
        .host_rdata (host_rdata),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rd     (mem_rd),
        .mem_wr     (mem_wr),
        .mem_rdata  (mem_rdata),
        .arb_err    (arb_err)
    );

    assign mem_rdata = mem[mem_addr];

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 8'h10 + 8'(i);
    end

    always @(posedge clk) begin
        if (mem_wr) mem[mem_addr] <= mem_wdata;
    end

    // Per-cycle monitor: bus, stall, ack, error and host read data.
    always @(negedge clk) begin
        if (rst_n && exp_q.size() > 0) begin
            exp_t e;
            exp_t act;
            e   = exp_q.pop_front();
            act = {mem_addr, mem_rd, mem_wr, cpu_stall, host_ack, arb_err, host_rdata};
            n_cmp++;
            if (act !== e) begin
                n_bad++;
                $display("FAIL cycle%0d a/rd/wr/st/ack/err/hrd got %h %b%b%b%b%b %h want %h %b%b%b%b%b %h",
                         cyc_k, act.a, act.rd, act.wr, act.st, act.ack, act.err, act.hrd,
                         e.a, e.rd, e.wr, e.st, e.ack, e.err, e.hrd);
            end
            cyc_k++;
        end
    end

    // Transaction monitor: every ack must match a queued host transaction.
    always @(negedge clk) begin
        if (rst_n && host_ack) begin
            n_cmp++;
            if (ack_q.size() == 0) begin
                n_bad++;
                $display("FAIL host_ack unexpected got 1 want 0");
            end else begin
                logic [7:0] p;
                p = ack_q.pop_front();
                if (host_rdata !== p) begin
                    n_bad++;
                    $display("FAIL ack_rdata got %h want %h", host_rdata, p);
                end
            end
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_cmp++;
        if (act !== want) begin
            n_bad++;
            $display("FAIL %s got %h want %h", nm, act, want);
        end
    endtask

    task automatic row(
        input logic rd, input logic wr, input logic [4:0] ad, input logic [7:0] wd,
        input logic hl, input logic hq, input logic hw, input logic [4:0] ha,
        input logic [7:0] hd, input logic [4:0] ea, input logic erd, input logic ewr,
        input logic est, input logic eack, input logic eerr, input logic [7:0] ehrd,
        input logic push, input logic [7:0] pv);
        cpu_rd     = rd;
        cpu_wr     = wr;
        cpu_addr   = ad;
        cpu_wdata  = wd;
        cpu_halted = hl;
        host_req   = hq;
        host_we    = hw;
        host_addr  = ha;
        host_wdata = hd;
        exp_q.push_back({ea, erd, ewr, est, eack, eerr, ehrd});
        if (push) ack_q.push_back(pv);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        cpu_rd = 0; cpu_wr = 0; cpu_addr = 0; cpu_wdata = 0; cpu_halted = 0;
        host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", 32'(host_ack), 0);
        chk("rst_err", 32'(arb_err), 0);
        chk("rst_mem_rd", 32'(mem_rd), 0);
        chk("rst_mem_wr", 32'(mem_wr), 0);
        chk("rst_stall", 32'(cpu_stall), 0);
        chk("rst_hrdata", 32'(host_rdata), 0);
        rst_n = 1'b1;

        // idle
        row(0,0,5'h00,8'h00, 0, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,0,8'h00, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,0,8'h00, 0,8'h00);
        // halted CPU, host write 1F <= A5 then read it back
        row(0,0,5'h00,8'h00, 1, 1,1,5'h1F,8'hA5, 5'h00,0,0,0,0,0,8'h00, 1,8'h00);
        row(0,0,5'h00,8'h00, 1, 1,1,5'h1F,8'hA5, 5'h1F,0,1,0,0,0,8'h00, 0,8'h00);
        row(0,0,5'h00,8'h00, 1, 1,1,5'h1F,8'hA5, 5'h00,0,0,0,1,0,8'h00, 0,8'h00);
        row(0,0,5'h00,8'h00, 1, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,0,8'h00, 0,8'h00);
        row(0,0,5'h00,8'h00, 1, 1,0,5'h1F,8'h00, 5'h00,0,0,0,0,0,8'h00, 1,8'hA5);
        row(0,0,5'h00,8'h00, 1, 1,0,5'h1F,8'h00, 5'h1F,1,0,0,0,0,8'h00, 0,8'h00);
        row(0,0,5'h00,8'h00, 1, 1,0,5'h1F,8'h00, 5'h00,0,0,0,1,0,8'hA5, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,0,8'hA5, 0,8'h00);
        // starvation bound: CPU reads every cycle, host read of 03
        row(1,0,5'h04,8'h00, 0, 1,0,5'h03,8'h00, 5'h04,1,0,0,0,0,8'hA5, 1,8'h13);
        row(1,0,5'h05,8'h00, 0, 1,0,5'h03,8'h00, 5'h05,1,0,0,0,0,8'hA5, 0,8'h00);
        row(1,0,5'h06,8'h00, 0, 1,0,5'h03,8'h00, 5'h06,1,0,0,0,0,8'hA5, 0,8'h00);
        row(1,0,5'h07,8'h00, 0, 1,0,5'h03,8'h00, 5'h07,1,0,0,0,0,8'hA5, 0,8'h00);
        row(1,0,5'h08,8'h00, 0, 1,0,5'h03,8'h00, 5'h03,1,0,1,0,0,8'hA5, 0,8'h00);
        row(1,0,5'h08,8'h00, 0, 1,0,5'h03,8'h00, 5'h08,1,0,0,1,0,8'h13, 0,8'h00);
        row(1,0,5'h09,8'h00, 0, 0,0,5'h00,8'h00, 5'h09,1,0,0,0,0,8'h13, 0,8'h00);
        // idle-cycle steal: host write 0A <= 5C
        row(0,0,5'h00,8'h00, 0, 1,1,5'h0A,8'h5C, 5'h00,0,0,0,0,0,8'h13, 1,8'h13);
        row(0,0,5'h00,8'h00, 0, 1,1,5'h0A,8'h5C, 5'h0A,0,1,0,0,0,8'h13, 0,8'h00);
        // back-to-back: req held through ack, next txn read 0A
        row(0,0,5'h00,8'h00, 0, 1,0,5'h0A,8'h00, 5'h00,0,0,0,1,0,8'h13, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 1,0,5'h0A,8'h00, 5'h00,0,0,0,0,0,8'h13, 1,8'h5C);
        row(0,0,5'h00,8'h00, 0, 1,0,5'h0A,8'h00, 5'h0A,1,0,0,0,0,8'h13, 0,8'h00);
        // next txn write 02 <= 77 while CPU reads then stores 02
        row(1,0,5'h02,8'h00, 0, 1,1,5'h02,8'h77, 5'h02,1,0,0,1,0,8'h5C, 1,8'h5C);
        row(1,0,5'h02,8'h00, 0, 1,1,5'h02,8'h77, 5'h02,1,0,0,0,0,8'h5C, 0,8'h00);
        row(0,1,5'h02,8'h11, 0, 1,1,5'h02,8'h77, 5'h02,0,1,0,0,0,8'h5C, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 1,1,5'h02,8'h77, 5'h00,0,0,0,0,0,8'h5C, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 1,1,5'h02,8'h77, 5'h02,0,1,0,0,0,8'h5C, 0,8'h00);
        // halted with a pending CPU read: host takes the slot, CPU stalls
        row(0,0,5'h00,8'h00, 0, 1,0,5'h02,8'h00, 5'h00,0,0,0,1,0,8'h5C, 1,8'h77);
        row(1,0,5'h05,8'h00, 1, 1,0,5'h02,8'h00, 5'h05,1,0,0,0,0,8'h5C, 0,8'h00);
        row(1,0,5'h05,8'h00, 1, 1,0,5'h02,8'h00, 5'h02,1,0,1,0,0,8'h5C, 0,8'h00);
        row(1,0,5'h05,8'h00, 0, 0,0,5'h00,8'h00, 5'h05,1,0,0,1,0,8'h77, 0,8'h00);
        // rd and wr together: write wins, error sticks
        row(1,1,5'h06,8'h99, 0, 0,0,5'h00,8'h00, 5'h06,0,1,0,0,0,8'h77, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,1,8'h77, 0,8'h00);
        row(0,0,5'h00,8'h00, 0, 0,0,5'h00,8'h00, 5'h00,0,0,0,0,1,8'h77, 0,8'h00);
        // host write 1E that is cut by reset during its slot
        row(0,0,5'h00,8'h00, 1, 1,1,5'h1E,8'h42, 5'h00,0,0,0,0,1,8'h77, 0,8'h00);

        chk("slot_mem_wr", 32'(mem_wr), 1);
        chk("slot_mem_addr", 32'(mem_addr), 32'h1E);
        #3;
        rst_n = 1'b0;
        #1;
        chk("mid_rst_ack", 32'(host_ack), 0);
        chk("mid_rst_err", 32'(arb_err), 0);
        chk("mid_rst_mem_wr", 32'(mem_wr), 0);
        chk("mid_rst_addr", 32'(mem_addr), 0);
        chk("mid_rst_hrdata", 32'(host_rdata), 0);
        host_req = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("post_rst_ack", 32'(host_ack), 0);
        end
        chk("ack_q_drained", 32'(ack_q.size()), 0);
        chk("exp_q_drained", 32'(exp_q.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
